// File: rtl/loa_sub_pipe.sv
// loa_sub_pipe: two-stage pipelined lower-part-OR approximate subtractor (A + ~B,
// low LOA_BITS approximated by OR) with valid/ready flow control and |error| statistics.
module loa_sub_pipe #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned LOA_BITS = 8,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned ERR_W    = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    input  logic             err_clr,
    output logic [CNT_W-1:0] op_count,
    output logic [ERR_W-1:0] err_sum,
    output logic [WIDTH:0]   err_max
);

    logic             s1_valid;
    logic             s2_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [WIDTH:0]   s2_err;

    logic             s1_adv;
    logic             s2_adv;
    logic             in_fire;
    logic             deliver;

    logic [WIDTH-1:0] approx_diff;
    logic             approx_cout;
    logic [WIDTH:0]   exact;
    logic [WIDTH:0]   approx_q;
    logic [WIDTH:0]   abs_err;

    logic [ERR_W:0]   err_ext;
    logic [ERR_W:0]   sum_ext;

    // out_ready -> in_ready is the only combinational path through the block.
    assign s2_adv    = ~s2_valid | out_ready;
    assign s1_adv    = s1_valid & s2_adv;
    assign in_ready  = ~s1_valid | s2_adv;
    assign in_fire   = in_valid & in_ready;
    assign deliver   = s2_valid & out_ready;
    assign out_valid = s2_valid;

    generate
        if (LOA_BITS == 0) begin : g_exact
            always_comb begin
                {approx_cout, approx_diff} = {1'b0, s1_a} + {1'b0, ~s1_b}
                                             + {{WIDTH{1'b0}}, 1'b1};
            end
        end else begin : g_loa
            localparam int unsigned UW = WIDTH - LOA_BITS;
            logic [UW:0] upper_sum;
            logic        cu;
            // The +1 of the two's complement is dropped; the top OR'd bit pair
            // supplies the only carry into the exact upper part.
            always_comb begin
                cu          = s1_a[LOA_BITS-1] & ~s1_b[LOA_BITS-1];
                upper_sum   = {1'b0, s1_a[WIDTH-1:LOA_BITS]} + {1'b0, ~s1_b[WIDTH-1:LOA_BITS]}
                              + {{UW{1'b0}}, cu};
                approx_diff = {upper_sum[UW-1:0], s1_a[LOA_BITS-1:0] | ~s1_b[LOA_BITS-1:0]};
                approx_cout = upper_sum[UW];
            end
        end
    endgenerate

    always_comb begin
        exact    = {1'b0, s1_a} + {1'b0, ~s1_b} + {{WIDTH{1'b0}}, 1'b1};
        approx_q = {approx_cout, approx_diff};
        abs_err  = (exact >= approx_q) ? (exact - approx_q) : (approx_q - exact);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (in_fire) begin
                s1_a <= a;
                s1_b <= b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            diff     <= '0;
            borrow   <= 1'b0;
            s2_err   <= '0;
        end else begin
            if (s2_adv) s2_valid <= s1_valid;
            if (s1_adv) begin
                diff   <= approx_diff;
                borrow <= ~approx_cout;
                s2_err <= abs_err;
            end
        end
    end

    assign err_ext = {{(ERR_W - WIDTH){1'b0}}, s2_err};
    assign sum_ext = {1'b0, err_sum} + err_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
            err_sum  <= '0;
            err_max  <= '0;
        end else if (err_clr) begin
            // A delivery coinciding with the clear restarts the statistics from it.
            if (deliver) begin
                op_count <= {{(CNT_W-1){1'b0}}, 1'b1};
                err_sum  <= err_ext[ERR_W-1:0];
                err_max  <= s2_err;
            end else begin
                op_count <= '0;
                err_sum  <= '0;
                err_max  <= '0;
            end
        end else if (deliver) begin
            if (op_count != '1) op_count <= op_count + 1'b1;
            err_sum <= sum_ext[ERR_W] ? '1 : sum_ext[ERR_W-1:0];
            if (s2_err > err_max) err_max <= s2_err;
        end
    end

endmodule

// File: tb/tb_loa_sub_pipe.sv
// Self-checking bench for loa_sub_pipe: directed steps plus randomized traffic scored
// against an arithmetic reference model, on an L=8 instance and an exact L=0 instance.
module tb_loa_sub_pipe;

    typedef struct {
        logic [31:0] diff;
        logic        borrow;
        logic [32:0] err;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic        iv8, ir8, ov8, or8, bor8, ec8;
    logic [31:0] a8, b8, diff8;
    logic [15:0] cnt8;
    logic [39:0] sum8;
    logic [32:0] max8;

    logic        iv0, ir0, ov0, or0, bor0, ec0;
    logic [31:0] a0, b0, diff0;
    logic [15:0] cnt0;
    logic [39:0] sum0;
    logic [32:0] max0;

    int          total;
    int          bad;
    exp_t        q8[$];
    exp_t        q0[$];
    logic [63:0] m_cnt, m_sum, m_max;

    loa_sub_pipe #(.WIDTH(32), .LOA_BITS(8), .CNT_W(16), .ERR_W(40)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .out_valid(ov8), .out_ready(or8), .diff(diff8), .borrow(bor8), .err_clr(ec8),
        .op_count(cnt8), .err_sum(sum8), .err_max(max8));

    loa_sub_pipe #(.WIDTH(32), .LOA_BITS(0), .CNT_W(16), .ERR_W(40)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
        .out_valid(ov0), .out_ready(or0), .diff(diff0), .borrow(bor0), .err_clr(ec0),
        .op_count(cnt0), .err_sum(sum0), .err_max(max0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: approximate and exact results from plain integer arithmetic.
    function automatic exp_t ref_sub(input logic [31:0] a, input logic [31:0] b,
                                     input int unsigned l);
        logic [63:0] av, nbv, e, q, low, up, cu, err;
        exp_t r;
        av  = {32'd0, a};
        nbv = {32'd0, ~b};
        e   = av + nbv + 64'd1;
        if (l == 0) begin
            q = e;
        end else begin
            low = (av | nbv) & ((64'd1 << l) - 64'd1);
            cu  = (av >> (l - 1)) & (nbv >> (l - 1)) & 64'd1;
            up  = (av >> l) + (nbv >> l) + cu;
            q   = (up << l) | low;
        end
        err      = (e >= q) ? (e - q) : (q - e);
        r.diff   = q[31:0];
        r.borrow = ~q[32];
        r.err    = err[32:0];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stats8(input string tag);
        chk({tag, "_cnt"}, {48'd0, cnt8}, m_cnt);
        chk({tag, "_sum"}, {24'd0, sum8}, m_sum);
        chk({tag, "_max"}, {31'd0, max8}, m_max);
    endtask

    // One clock cycle on the L=8 instance; inputs driven 1ns after the edge, handshakes
    // observed mid-cycle.
    task automatic step8(input logic iv, input logic [31:0] a, input logic [31:0] b,
                         input logic rdy, output logic dlv, output logic acc);
        exp_t e;
        iv8 = iv; a8 = a; b8 = b; or8 = rdy;
        #4;
        acc = iv8 & ir8;
        dlv = ov8 & or8;
        if (acc) q8.push_back(ref_sub(a, b, 8));
        if (dlv) begin
            chk("no_dup8", {63'd0, q8.size() != 0}, 64'd1);
            if (q8.size() != 0) begin
                e = q8.pop_front();
                chk("diff8", {32'd0, diff8}, {32'd0, e.diff});
                chk("borrow8", {63'd0, bor8}, {63'd0, e.borrow});
                if (ec8) begin
                    m_cnt = 1; m_sum = {31'd0, e.err}; m_max = {31'd0, e.err};
                end else begin
                    if (m_cnt < 64'd65535) m_cnt++;
                    m_sum = (m_sum + e.err > 64'hFF_FFFF_FFFF) ? 64'hFF_FFFF_FFFF : m_sum + e.err;
                    if ({31'd0, e.err} > m_max) m_max = {31'd0, e.err};
                end
            end
        end else if (ec8) begin
            m_cnt = 0; m_sum = 0; m_max = 0;
        end
        @(posedge clk); #1;
    endtask

    task automatic step0(input logic iv, input logic [31:0] a, input logic [31:0] b,
                         output logic dlv);
        exp_t e;
        iv0 = iv; a0 = a; b0 = b; or0 = 1'b1;
        #4;
        dlv = ov0 & or0;
        if (iv0 & ir0) q0.push_back(ref_sub(a, b, 0));
        if (dlv) begin
            chk("no_dup0", {63'd0, q0.size() != 0}, 64'd1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                chk("diff0", {32'd0, diff0}, {32'd0, e.diff});
                chk("borrow0", {63'd0, bor0}, {63'd0, e.borrow});
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic        d, acc, hv, hold, hold_bor;
        logic [31:0] ha, hb, hold_diff;
        total = 0; bad = 0;
        m_cnt = 0; m_sum = 0; m_max = 0;
        rst_n = 1'b0;
        iv8 = 0; a8 = 0; b8 = 0; or8 = 0; ec8 = 0;
        iv0 = 0; a0 = 0; b0 = 0; or0 = 0; ec0 = 0;

        #2;
        chk("rst_ov8", {63'd0, ov8}, 64'd0);
        chk("rst_diff8", {32'd0, diff8}, 64'd0);
        chk("rst_borrow8", {63'd0, bor8}, 64'd0);
        chk_stats8("rst");
        chk("rst_ov0", {63'd0, ov0}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rdy_after_rst", {63'd0, ir8}, 64'd1);

        // Latency and the 0x100 - 1 example.
        step8(1, 32'h100, 32'h1, 1, d, acc);
        chk("lat_accept", {63'd0, acc}, 64'd1);
        chk("lat_e1_valid", {63'd0, ov8}, 64'd0);
        step8(0, 0, 0, 1, d, acc);
        chk("lat_e2_valid", {63'd0, ov8}, 64'd1);
        chk("lat_diff", {32'd0, diff8}, 64'hFE);
        chk("lat_borrow", {63'd0, bor8}, 64'd0);
        step8(0, 0, 0, 1, d, acc);
        chk("lat_deliver", {63'd0, d}, 64'd1);
        chk("lat_sum", {24'd0, sum8}, 64'd1);
        chk_stats8("lat");

        // a == b: approximation falls just below zero.
        step8(1, 32'd5, 32'd5, 1, d, acc);
        step8(0, 0, 0, 1, d, acc);
        chk("eq_diff", {32'd0, diff8}, 64'hFFFF_FFFF);
        chk("eq_borrow", {63'd0, bor8}, 64'd1);
        step8(0, 0, 0, 1, d, acc);
        chk("eq_max", {31'd0, max8}, 64'd1);
        chk_stats8("eq");

        // Back-to-back: eight results on eight consecutive cycles.
        for (int i = 0; i < 8; i++) begin
            step8(1, $urandom, $urandom, 1, d, acc);
            chk("b2b_accept", {63'd0, acc}, 64'd1);
            if (i >= 2) chk("b2b_deliver", {63'd0, d}, 64'd1);
        end
        for (int i = 0; i < 3; i++) begin
            step8(0, 0, 0, 1, d, acc);
            chk("b2b_tail", {63'd0, d}, (i < 2) ? 64'd1 : 64'd0);
        end
        chk("b2b_empty", q8.size(), 64'd0);
        chk_stats8("b2b");

        // Stall: two accepts then backpressure; output held stable.
        ha = $urandom; hb = $urandom;
        hold_diff = '0; hold_bor = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step8(1, ha, hb, 0, d, acc);
            chk("stall_accept", {63'd0, acc}, (i < 2) ? 64'd1 : 64'd0);
            chk("stall_no_deliver", {63'd0, d}, 64'd0);
            if (acc) begin ha = $urandom; hb = $urandom; end
            if (i == 1) begin hold_diff = diff8; hold_bor = bor8; end
            if (i >= 1) begin
                chk("stall_valid", {63'd0, ov8}, 64'd1);
                chk("stall_diff", {32'd0, diff8}, {32'd0, hold_diff});
                chk("stall_borrow", {63'd0, bor8}, {63'd0, hold_bor});
            end
        end
        step8(1, ha, hb, 1, d, acc);
        chk("stall_resume", {63'd0, acc}, 64'd1);
        repeat (4) step8(0, 0, 0, 1, d, acc);
        chk("stall_empty", q8.size(), 64'd0);
        chk_stats8("stall");

        // err_clr alone, then err_clr coinciding with a delivery.
        ec8 = 1'b1;
        step8(0, 0, 0, 1, d, acc);
        ec8 = 1'b0;
        chk("clr_cnt", {48'd0, cnt8}, 64'd0);
        chk("clr_sum", {24'd0, sum8}, 64'd0);
        chk("clr_max", {31'd0, max8}, 64'd0);
        repeat (3) step8(1, $urandom, $urandom, 1, d, acc);
        repeat (3) step8(0, 0, 0, 1, d, acc);
        step8(1, 32'd5, 32'd5, 1, d, acc);
        step8(0, 0, 0, 1, d, acc);
        ec8 = 1'b1;
        step8(0, 0, 0, 1, d, acc);
        ec8 = 1'b0;
        chk("clrdlv_deliver", {63'd0, d}, 64'd1);
        chk("clrdlv_cnt", {48'd0, cnt8}, 64'd1);
        chk("clrdlv_sum", {24'd0, sum8}, 64'd1);
        chk("clrdlv_max", {31'd0, max8}, 64'd1);
        chk_stats8("clrdlv");

        // Random traffic with random backpressure; source holds unaccepted operands.
        hold = 1'b0; hv = 1'b0; ha = 0; hb = 0;
        for (int i = 0; i < 80; i++) begin
            if (!hold) begin
                hv = 1'($urandom_range(0, 1));
                ha = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
                hb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            end
            step8(hv, ha, hb, 1'($urandom_range(0, 1)), d, acc);
            hold = hv & ~acc;
        end
        if (hold) step8(1, ha, hb, 1, d, acc);
        repeat (3) step8(0, 0, 0, 1, d, acc);
        chk("rand_empty", q8.size(), 64'd0);
        chk_stats8("rand");

        // Exact instance.
        step0(1, 32'd3, 32'd5, d);
        step0(0, 0, 0, d);
        chk("ex_diff", {32'd0, diff0}, 64'hFFFF_FFFE);
        chk("ex_borrow", {63'd0, bor0}, 64'd1);
        step0(0, 0, 0, d);
        chk("ex_err", {24'd0, sum0}, 64'd0);
        ec0 = 1'b1;
        step0(0, 0, 0, d);
        ec0 = 1'b0;
        for (int i = 0; i < 10; i++) step0(1, $urandom, $urandom, d);
        repeat (3) step0(0, 0, 0, d);
        chk("ex_cnt", {48'd0, cnt0}, 64'd10);
        chk("ex_sum", {24'd0, sum0}, 64'd0);
        chk("ex_max", {31'd0, max0}, 64'd0);
        chk("ex_empty", q0.size(), 64'd0);

        // Reset with both stages full: everything discarded.
        repeat (3) step8(1, $urandom, $urandom, 0, d, acc);
        chk("prerst_valid", {63'd0, ov8}, 64'd1);
        iv8 = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_ov", {63'd0, ov8}, 64'd0);
        chk("midrst_diff", {32'd0, diff8}, 64'd0);
        q8.delete();
        m_cnt = 0; m_sum = 0; m_max = 0;
        chk_stats8("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            step8(0, 0, 0, 1, d, acc);
            chk("postrst_no_out", {63'd0, d}, 64'd0);
        end
        chk_stats8("postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
